// File: rtl/writeback_commit_if.sv
// Execute-to-commit handshake and regfile commit port bundle for writeback_commit.
// slave: the commit stage itself; master: the execute side / regfile observer.
interface writeback_commit_if;
   logic        exu_valid_i;
   logic        exu_ready_o;
   logic [31:0] exu_pc_i;
   logic        exu_wena_i;
   logic [4:0]  exu_waddr_i;
   logic [31:0] exu_wdata_i;
   logic        exu_ebreak_i;
   logic        commit_valid_o;
   logic        commit_wena_o;
   logic [4:0]  commit_waddr_o;
   logic [31:0] commit_wdata_o;
   logic [31:0] commit_pc_o;
   logic        halt_o;
   logic [63:0] commit_count_o;

   modport slave (
      input  exu_valid_i, exu_pc_i, exu_wena_i, exu_waddr_i, exu_wdata_i, exu_ebreak_i,
      output exu_ready_o, commit_valid_o, commit_wena_o, commit_waddr_o, commit_wdata_o,
             commit_pc_o, halt_o, commit_count_o
   );

   modport master (
      output exu_valid_i, exu_pc_i, exu_wena_i, exu_waddr_i, exu_wdata_i, exu_ebreak_i,
      input  exu_ready_o, commit_valid_o, commit_wena_o, commit_waddr_o, commit_wdata_o,
             commit_pc_o, halt_o, commit_count_o
   );
endinterface

// File: rtl/writeback_commit.sv
// In-order commit stage: FIFO-buffers execute results and retires one per cycle to the regfile.
// Optional COMMIT_BYPASS_EN: an accept into an empty FIFO loads the commit outputs directly.
module writeback_commit #(
   parameter int unsigned DEPTH = 2
) (
   input  logic              clock,
   input  logic              reset,
   writeback_commit_if.slave bus
);
   localparam int unsigned AW    = $clog2(DEPTH);
   localparam int unsigned PTR_W = AW + 1;

   typedef struct packed {
      logic [31:0] pc;
      logic        wena;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic        ebreak;
   } entry_t;

   typedef struct packed {
      logic [31:0] pc;
      logic        wena;
      logic [4:0]  waddr;
      logic [31:0] wdata;
   } commit_t;

   typedef enum logic {RUN, HALT} state_t;

   state_t           state_q, state_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   entry_t           mem_q [DEPTH];
   entry_t           mem_d [DEPTH];
   commit_t          out_q, out_d;
   logic             cvalid_q, cvalid_d;
   logic [63:0]      count_q, count_d;

   logic   full, empty, run, ready, push, pop, bypass;
   entry_t in_e, head_e;

   always_comb begin
      full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      empty  = (wr_ptr_q == rd_ptr_q);
      run    = (state_q == RUN);
      ready  = !full && run;
      push   = bus.exu_valid_i && ready;
      pop    = !empty && run;
`ifdef COMMIT_BYPASS_EN
      bypass = push && empty;
`else
      bypass = 1'b0;
`endif
      in_e   = '{pc: bus.exu_pc_i, wena: bus.exu_wena_i, waddr: bus.exu_waddr_i,
                 wdata: bus.exu_wdata_i, ebreak: bus.exu_ebreak_i};
      head_e = mem_q[rd_ptr_q[AW-1:0]];
   end

   // Retire path: pop the head, or take the bypassed packet when the FIFO is empty
   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      mem_d    = mem_q;
      out_d    = out_q;
      cvalid_d = 1'b0;
      count_d  = count_q;

      if (pop) begin
         out_d    = '{pc: head_e.pc, wena: head_e.wena, waddr: head_e.waddr, wdata: head_e.wdata};
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
         cvalid_d = 1'b1;
         count_d  = count_q + 64'd1;
         if (head_e.ebreak) state_d = HALT;
      end else if (bypass) begin
         out_d    = '{pc: in_e.pc, wena: in_e.wena, waddr: in_e.waddr, wdata: in_e.wdata};
         cvalid_d = 1'b1;
         count_d  = count_q + 64'd1;
         if (in_e.ebreak) state_d = HALT;
      end

      if (push && !bypass) begin
         mem_d[wr_ptr_q[AW-1:0]] = in_e;
         wr_ptr_d                = wr_ptr_q + PTR_W'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= RUN;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         out_q    <= '0;
         cvalid_q <= 1'b0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         out_q    <= out_d;
         cvalid_q <= cvalid_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: validity is tracked by the pointers
   always_ff @(posedge clock) begin
      mem_q <= mem_d;
   end

   assign bus.exu_ready_o    = ready;
   assign bus.commit_valid_o = cvalid_q;
   assign bus.commit_wena_o  = out_q.wena;
   assign bus.commit_waddr_o = out_q.waddr;
   assign bus.commit_wdata_o = out_q.wdata;
   assign bus.commit_pc_o    = out_q.pc;
   assign bus.halt_o         = (state_q == HALT);
   assign bus.commit_count_o = count_q;
endmodule

// File: tb/tb_writeback_commit.sv
// Directed self-checking bench for writeback_commit: latency, ordering, x0, ebreak halt, reset.
module tb_writeback_commit;
`ifdef COMMIT_BYPASS_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 2;
`endif

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   longint unsigned exp_count = 0;

   typedef struct {
      logic [31:0] pc;
      logic        wena;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic        halt;
      int          cyc;
   } rec_t;
   rec_t q[$];

   writeback_commit_if bus ();
   writeback_commit #(.DEPTH(2)) dut (.clock(clock), .reset(reset), .bus(bus));

   always #5 clock = ~clock;
   always @(posedge clock) cyc = cyc + 1;

   // Retire monitor, sampled just after each active edge
   always @(posedge clock) begin
      #1;
      if (bus.commit_valid_o === 1'b1)
         q.push_back('{pc: bus.commit_pc_o, wena: bus.commit_wena_o, waddr: bus.commit_waddr_o,
                       wdata: bus.commit_wdata_o, halt: bus.halt_o, cyc: cyc});
   end

   task automatic idle(input int n);
      bus.exu_valid_i = 1'b0;
      repeat (n) @(negedge clock);
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge with valid still high
   task automatic send(input logic [31:0] pc, input logic wena, input logic [4:0] waddr,
                       input logic [31:0] wdata, input logic eb, output int acc);
      int n = 0;
      bus.exu_valid_i  = 1'b1;
      bus.exu_pc_i     = pc;
      bus.exu_wena_i   = wena;
      bus.exu_waddr_i  = waddr;
      bus.exu_wdata_i  = wdata;
      bus.exu_ebreak_i = eb;
      acc = -1;
      while (bus.exu_ready_o !== 1'b1 && n < 50) begin
         @(negedge clock);
         n++;
      end
      if (bus.exu_ready_o !== 1'b1) begin
         checks++; failures++;
         $display("FAIL send_timeout pc=%h ready=%b required=1", pc, bus.exu_ready_o);
      end else begin
         acc = cyc + 1;
         @(negedge clock);
      end
   endtask

   task automatic do_reset();
      bus.exu_valid_i = 1'b0;
      reset = 1'b1;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
   endtask

   task automatic check_reset_values(input string tag);
      checks++; if (bus.commit_valid_o !== 1'b0) begin failures++; $display("FAIL %s_valid got=%b exp=0", tag, bus.commit_valid_o); end
      checks++; if (bus.commit_wena_o !== 1'b0) begin failures++; $display("FAIL %s_wena got=%b exp=0", tag, bus.commit_wena_o); end
      checks++; if (bus.commit_waddr_o !== 5'd0) begin failures++; $display("FAIL %s_waddr got=%h exp=0", tag, bus.commit_waddr_o); end
      checks++; if (bus.commit_wdata_o !== 32'd0) begin failures++; $display("FAIL %s_wdata got=%h exp=0", tag, bus.commit_wdata_o); end
      checks++; if (bus.commit_pc_o !== 32'd0) begin failures++; $display("FAIL %s_pc got=%h exp=0", tag, bus.commit_pc_o); end
      checks++; if (bus.halt_o !== 1'b0) begin failures++; $display("FAIL %s_halt got=%b exp=0", tag, bus.halt_o); end
      checks++; if (bus.commit_count_o !== 64'd0) begin failures++; $display("FAIL %s_count got=%0d exp=0", tag, bus.commit_count_o); end
      checks++; if (bus.exu_ready_o !== 1'b1) begin failures++; $display("FAIL %s_ready got=%b exp=1", tag, bus.exu_ready_o); end
   endtask

   task automatic test_reset();
      do_reset();
      check_reset_values("reset");
      exp_count = 0;
   endtask

   task automatic test_single();
      int acc;
      q.delete();
      send(32'h8000_0000, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, acc);
      idle(5);
      exp_count += 1;
      checks++;
      if (q.size() != 1) begin
         failures++; $display("FAIL single_pulses got=%0d exp=1", q.size());
      end else begin
         checks++; if (q[0].pc !== 32'h8000_0000 || q[0].wena !== 1'b1 || q[0].waddr !== 5'd5 || q[0].wdata !== 32'hDEAD_BEEF) begin
            failures++; $display("FAIL single_fields got=%h/%b/%0d/%h exp=80000000/1/5/deadbeef", q[0].pc, q[0].wena, q[0].waddr, q[0].wdata);
         end
         checks++; if (q[0].cyc != acc + LAT - 1) begin
            failures++; $display("FAIL single_latency got_cycle=%0d exp_cycle=%0d", q[0].cyc, acc + LAT - 1);
         end
      end
      checks++; if (bus.commit_count_o !== exp_count) begin failures++; $display("FAIL single_count got=%0d exp=%0d", bus.commit_count_o, exp_count); end
      checks++; if (bus.commit_pc_o !== 32'h8000_0000 || bus.commit_wdata_o !== 32'hDEAD_BEEF) begin
         failures++; $display("FAIL single_hold got=%h/%h exp=80000000/deadbeef", bus.commit_pc_o, bus.commit_wdata_o);
      end
   endtask

   task automatic test_back_to_back();
      int acc, prev;
      int gaps = 0;
      int bad = 0;
      q.delete();
      prev = -1;
      for (int i = 1; i <= 8; i++) begin
         send(32'h100 + 32'(i * 4), 1'b1, 5'(i), 32'h5000 + 32'(i), 1'b0, acc);
         if (prev >= 0 && acc != prev + 1) gaps++;
         prev = acc;
      end
      idle(5);
      exp_count += 8;
      checks++; if (gaps != 0) begin failures++; $display("FAIL b2b_ready_gaps got=%0d exp=0", gaps); end
      checks++;
      if (q.size() != 8) begin
         failures++; $display("FAIL b2b_pulses got=%0d exp=8", q.size());
      end else begin
         for (int i = 0; i < 8; i++)
            if (q[i].waddr !== 5'(i + 1) || q[i].wdata !== 32'h5000 + 32'(i + 1) || (i > 0 && q[i].cyc != q[i-1].cyc + 1)) bad++;
         checks++; if (bad != 0) begin failures++; $display("FAIL b2b_order bad_entries=%0d exp=0", bad); end
      end
      checks++; if (bus.commit_count_o !== exp_count) begin failures++; $display("FAIL b2b_count got=%0d exp=%0d", bus.commit_count_o, exp_count); end
   endtask

   task automatic test_fill_wrap();
      int acc;
      int bad = 0;
      q.delete();
      for (int i = 0; i < 20; i++)
         send(32'h1000 + 32'(i * 4), 1'(i), 5'(i), 32'hA5A5_0000 ^ 32'(i), 1'b0, acc);
      idle(5);
      exp_count += 20;
      checks++;
      if (q.size() != 20) begin
         failures++; $display("FAIL wrap_pulses got=%0d exp=20", q.size());
      end else begin
         for (int i = 0; i < 20; i++)
            if (q[i].pc !== 32'h1000 + 32'(i * 4) || q[i].wena !== 1'(i) || q[i].waddr !== 5'(i) ||
                q[i].wdata !== (32'hA5A5_0000 ^ 32'(i))) bad++;
         checks++; if (bad != 0) begin failures++; $display("FAIL wrap_data bad_entries=%0d exp=0", bad); end
      end
      checks++; if (bus.commit_count_o !== exp_count) begin failures++; $display("FAIL wrap_count got=%0d exp=%0d", bus.commit_count_o, exp_count); end
   endtask

   task automatic test_x0();
      int acc;
      q.delete();
      send(32'h2000, 1'b1, 5'd0, 32'h1234, 1'b0, acc);
      idle(4);
      exp_count += 1;
      checks++;
      if (q.size() != 1) begin
         failures++; $display("FAIL x0_pulses got=%0d exp=1", q.size());
      end else begin
         checks++; if (q[0].wena !== 1'b1 || q[0].waddr !== 5'd0 || q[0].wdata !== 32'h1234) begin
            failures++; $display("FAIL x0_fields got=%b/%0d/%h exp=1/0/1234", q[0].wena, q[0].waddr, q[0].wdata);
         end
      end
   endtask

   task automatic test_ebreak();
      int acc;
      int bad_ready = 0;
      int bad_stable = 0;
      q.delete();
      send(32'h3000, 1'b1, 5'd1, 32'hAAAA, 1'b0, acc);
      send(32'h3004, 1'b0, 5'd0, 32'h0, 1'b1, acc);
      bus.exu_pc_i = 32'h3008; bus.exu_wena_i = 1'b1; bus.exu_waddr_i = 5'd3;
      bus.exu_wdata_i = 32'hCCCC; bus.exu_ebreak_i = 1'b0; bus.exu_valid_i = 1'b1;
      @(negedge clock);
      @(negedge clock);
      exp_count += 2;
      for (int i = 0; i < 10; i++) begin
         if (bus.exu_ready_o !== 1'b0) bad_ready++;
         if (bus.commit_count_o !== exp_count || bus.commit_valid_o !== 1'b0 || bus.halt_o !== 1'b1) bad_stable++;
         @(negedge clock);
      end
      bus.exu_valid_i = 1'b0;
      checks++; if (bad_ready != 0) begin failures++; $display("FAIL ebreak_ready high_cycles=%0d exp=0", bad_ready); end
      checks++; if (bad_stable != 0) begin failures++; $display("FAIL ebreak_stable bad_cycles=%0d exp=0 count=%0d", bad_stable, bus.commit_count_o); end
      checks++;
      if (q.size() != 2) begin
         failures++; $display("FAIL ebreak_pulses got=%0d exp=2", q.size());
      end else begin
         checks++; if (q[0].pc !== 32'h3000 || q[0].halt !== 1'b0) begin
            failures++; $display("FAIL ebreak_first got=%h/%b exp=3000/0", q[0].pc, q[0].halt);
         end
         checks++; if (q[1].pc !== 32'h3004 || q[1].halt !== 1'b1) begin
            failures++; $display("FAIL ebreak_second got=%h/%b exp=3004/1", q[1].pc, q[1].halt);
         end
      end
   endtask

   task automatic test_reset_mid();
      q.delete();
      reset = 1'b1;
      @(negedge clock);
      check_reset_values("midreset");
      reset = 1'b0;
      exp_count = 0;
      idle(6);
      checks++; if (q.size() != 0) begin failures++; $display("FAIL midreset_stale_retire got=%0d exp=0", q.size()); end
      checks++; if (bus.exu_ready_o !== 1'b1 || bus.halt_o !== 1'b0) begin
         failures++; $display("FAIL midreset_run got_ready=%b got_halt=%b exp=1/0", bus.exu_ready_o, bus.halt_o);
      end
   endtask

   initial begin
      bus.exu_valid_i  = 1'b0;
      bus.exu_pc_i     = '0;
      bus.exu_wena_i   = 1'b0;
      bus.exu_waddr_i  = '0;
      bus.exu_wdata_i  = '0;
      bus.exu_ebreak_i = 1'b0;
      @(negedge clock);
      test_reset();
      test_single();
      test_back_to_back();
      test_fill_wrap();
      test_x0();
      test_ebreak();
      test_reset_mid();
      test_single();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/writeback_commit.md
# writeback_commit

Commit stage of the simple pipeline: the producer side of the regfile commit port. Accepts completed instructions from execute/LSU over a valid/ready handshake, buffers them in order in a small FIFO, and retires one per cycle by driving a single-cycle commit pulse (valid, write enable, address, data) to the regfile, which writes data and clears the scoreboard busy bit. Also halts retirement on `ebreak` and keeps a retired-instruction counter.

## Interface
- `DEPTH`, 2, FIFO entries; power of two, ≥2.
- `clock`  in  1  clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high.
- `exu_valid_i`  in  1  result packet valid.
- `exu_ready_o`  out  1  block can accept a packet this cycle.
- `exu_pc_i`  in  32  PC of instruction.
- `exu_wena_i`  in  1  instruction writes rd.
- `exu_waddr_i`  in  5  rd index.
- `exu_wdata_i`  in  32  rd value.
- `exu_ebreak_i`  in  1  instruction is `ebreak`.
- `commit_valid_o`  out  1  one-cycle retire pulse.
- `commit_wena_o`  out  1  retire writes rd.
- `commit_waddr_o`  out  5  rd index.
- `commit_wdata_o`  out  32  rd value.
- `commit_pc_o`  out  32  retired PC.
- `halt_o`  out  1  `ebreak` retired; sticky until reset.
- `commit_count_o`  out  64  instructions retired since reset.

## Operation
- Handshake: transfer at posedge when `exu_valid_i && exu_ready_o`. `exu_ready_o = !full && !halt`; purely from registered state, no combinational path from `exu_valid_i`.
- FIFO: `DEPTH` entries {pc, wena, waddr, wdata, ebreak}, read/write pointers of log2(DEPTH)+1 bits, wrap naturally; full = MSBs differ and low bits equal; empty = pointers equal.
- Retire: state RUN, each posedge with FIFO non-empty pops head into output registers and sets `commit_valid_o=1` for the following cycle; otherwise `commit_valid_o=0`. Max one retire per cycle, strictly in acceptance order.
- Output fields registered; hold last retired value when `commit_valid_o=0` (only valid-qualified meaning).
- x0: `wena=1, waddr=0` forwarded unchanged (regfile suppresses the write but must clear busy[0]).
- Push and pop in same cycle allowed when neither full-blocked nor empty; occupancy unchanged.
- `commit_count_o` increments by 1 on every cycle `commit_valid_o=1` is asserted (counted at the pop edge), 64-bit wrap.
- States: RUN → HALT at the pop edge of an entry with ebreak=1 (that entry still retires normally, `halt_o=1` same cycle as its `commit_valid_o`). HALT: no pops, no accepts, `exu_ready_o=0`; FIFO contents frozen. Exit only by reset.
- Reset (also mid-operation): pointers cleared (FIFO empty, in-flight entries dropped), state RUN, `commit_valid_o=0`, `commit_wena_o=0`, `commit_waddr_o=0`, `commit_wdata_o=0`, `commit_pc_o=0`, `halt_o=0`, `commit_count_o=0`; `exu_ready_o=1` first cycle after reset.

## Timing
- Base latency: packet accepted at edge N → stored in FIFO; popped at edge N+1 → `commit_valid_o` high during cycle N+1..N+2 (2 cycles).
- Commit outputs stable for a whole cycle after a posedge, so a negedge-sampling regfile sees them settled.
- Sustained throughput 1 packet/cycle with `DEPTH≥2`.

## Configuration
- `COMMIT_BYPASS_EN` defined: when FIFO empty and state RUN, an accepted packet loads the output registers directly at edge N (`commit_valid_o` high cycle N..N+1, latency 1); FIFO untouched; ebreak/count/halt rules identical. When FIFO non-empty, normal path (ordering preserved).
- Not defined: all packets go through the FIFO, latency 2.

## Test plan
- Reset then single packet pc=0x80000000, wena=1, waddr=5, wdata=0xDEADBEEF → one `commit_valid_o` pulse with those fields, 2 cycles after accept (1 with `COMMIT_BYPASS_EN`); `commit_count_o`=1.
- Back-to-back 8 packets waddr=1..8, valid held high → 8 consecutive pulses in order, `exu_ready_o` never drops, count=8.
- `DEPTH=2`, force fill by sending 3 packets in consecutive cycles with bypass off and retire clean → ready deasserts only when full, pointers wrap, no loss/duplication after 20 packets.
- Packet wena=1, waddr=0, wdata=0x1234 → pulse with wena=1, waddr=0 forwarded unchanged.
- Packets A, ebreak B, C → A and B retire, `halt_o`=1 with B's pulse, C never retires, `exu_ready_o`=0, count=2 stable for 10 cycles.
- Assert reset with 2 entries queued and halted → next cycle all outputs at reset values, `exu_ready_o`=1, queued entries never retire.
